ja_traffic_light: RTL and testbench



---
 rtl/ja_traffic_light_pkg.sv | 49 ++++
 rtl/ja_tl_timer.sv | 35 +++
 rtl/ja_traffic_light.sv | 125 ++++++++++++
 tb/tb_ja_traffic_light.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ja_traffic_light_pkg.sv
// Shared definitions for the ja_traffic_light tile.
//   - state_t        : 2-bit light state encoding (RED=00, GREEN=01, YELLOW=10; 11 unused)
//   - uo_out indices : lamp bits, state code LSB, pedestrian-pending bit
//   - ui_in indices  : reset, hold, pedestrian request
//   - helpers        : counter width sizing and lamp decode
package ja_traffic_light_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  // uo_out bit positions
  localparam int GREEN_BIT  = 0;
  localparam int YELLOW_BIT = 1;
  localparam int RED_BIT    = 2;
  localparam int STATE_LSB  = 3;
  localparam int PED_BIT    = 5;

  // ui_in bit positions
  localparam int RST_BIT     = 0;
  localparam int HOLD_BIT    = 1;
  localparam int PED_REQ_BIT = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter must reach max_dur-1; keep at least one bit for the degenerate case.
  function automatic int cnt_width(input int max_dur);
    return (max_dur <= 2) ? 1 : $clog2(max_dur);
  endfunction

  // Returns {red, yellow, green}. The unused code 11 shows red so a corrupted
  // state never presents green or yellow to traffic.
  function automatic logic [2:0] lamp_decode(input logic [1:0] st);
    logic [2:0] lamps;
    case (st)
      2'b01:   lamps = 3'b001;
      2'b10:   lamps = 3'b010;
      default: lamps = 3'b100;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/ja_tl_timer.sv
// Per-state cycle counter for the traffic-light FSM.
// Counts up from zero while enabled; tc flags that the count equals limit.
//   clk   : system clock
//   rst   : synchronous active-high reset, forces cnt to 0 (ignores en)
//   en    : count enable; when low the count is frozen (hold)
//   clear : restart at 0 on the next enabled edge (state change)
//   limit : last count value of the current state (duration - 1)
//   cnt   : current count
//   tc    : terminal count, cnt == limit
module ja_tl_timer
  import ja_traffic_light_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clear) cnt <= '0;
      else       cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/ja_traffic_light.sv
// Fixed-time single-intersection traffic-light controller (Tiny Tapeout tile).
// Cycles RED -> GREEN -> YELLOW -> RED with per-state durations in clock cycles.
// A pedestrian request latches ped_pending and cuts GREEN short once the
// minimum green time has elapsed; hold freezes the whole controller.
//   clk    : system clock
//   ui_in  : [0] rst (sync, active-high), [1] hold, [2] ped_req, [7:3] ignored
//   uo_out : [0] green, [1] yellow, [2] red, [4:3] state code,
//            [5] ped_pending, [7:6] tied 0
module ja_traffic_light
  import ja_traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 10,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int PED_MIN_GREEN = 3
) (
  input  logic       clk,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam int MAX_DUR = max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);
  localparam int CNT_W   = cnt_width(MAX_DUR);

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_MIN_GREEN - 1);

  logic rst;
  logic hold;
  logic ped_req;
  logic unused_ui;

  assign rst       = ui_in[RST_BIT];
  assign hold      = ui_in[HOLD_BIT];
  assign ped_req   = ui_in[PED_REQ_BIT];
  assign unused_ui = &{1'b0, ui_in[7:3]};

  state_t           state;
  state_t           state_nxt;
  logic             advance;
  logic             ped_pending;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic [2:0]       lamps;

  always_comb begin
    case (state)
      ST_GREEN:  limit = GREEN_LAST;
      ST_YELLOW: limit = YELLOW_LAST;
      default:   limit = RED_LAST;
    endcase
  end

  // Next-state selection; advance restarts the timer on every state change.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      ST_RED: begin
        if (tc) begin
          state_nxt = ST_GREEN;
          advance   = 1'b1;
        end
      end
      ST_GREEN: begin
        // Pedestrian early exit and normal expiry both lead to YELLOW.
        if ((ped_pending && (cnt >= PED_LAST)) || tc) begin
          state_nxt = ST_YELLOW;
          advance   = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (tc) begin
          state_nxt = ST_RED;
          advance   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RED;
        advance   = 1'b1;
      end
    endcase
  end

  ja_tl_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (~hold),
    .clear(advance),
    .limit(limit),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RED;
      ped_pending <= 1'b0;
    end else if (!hold) begin
      state <= state_nxt;
      // Entering RED serves the request; a request on that same edge is dropped.
      if (advance && (state_nxt == ST_RED)) ped_pending <= 1'b0;
      else if (ped_req)                     ped_pending <= 1'b1;
    end
  end

  // Lamps are decoded from the state register only, so inputs never reach
  // the lamp pins combinationally.
  assign lamps = lamp_decode(state);

  always_comb begin
    uo_out                   = '0;
    uo_out[GREEN_BIT]        = lamps[0];
    uo_out[YELLOW_BIT]       = lamps[1];
    uo_out[RED_BIT]          = lamps[2];
    uo_out[STATE_LSB +: 2]   = state;
    uo_out[PED_BIT]          = ped_pending;
  end

endmodule

// File: tb/tb_ja_traffic_light.sv
// Directed bench for ja_traffic_light with default parameters
// (RED 10, GREEN 8, YELLOW 3, pedestrian minimum green 3).
module tb_ja_traffic_light;

  logic       clk = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;

  always #5 clk = ~clk;

  ja_traffic_light dut (
    .clk   (clk),
    .ui_in (ui_in),
    .uo_out(uo_out)
  );

  localparam logic [7:0] I_NONE = 8'h00;
  localparam logic [7:0] I_RST  = 8'h01;
  localparam logic [7:0] I_HOLD = 8'h02;
  localparam logic [7:0] I_PED  = 8'h04;

  // Full uo_out words: lamps | state code << 3 | ped_pending << 5
  localparam logic [7:0] O_RED = 8'h04;
  localparam logic [7:0] O_GRN = 8'h09;
  localparam logic [7:0] O_YEL = 8'h12;
  localparam logic [7:0] O_P   = 8'h20;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [7:0] ui, input logic [7:0] exp, input int n);
    vec_t v;
    v.ui  = ui;
    v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, clock once, sample at the next falling edge.
  task automatic step(input logic [7:0] ui);
    ui_in = ui;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp;
    logic [1:0] exp_state;
    logic [2:0] lamp;
    int p;

    // Hold at GREEN cycle 4 for 5 edges, then the remaining 4 GREEN cycles.
    add(I_RST,  O_RED, 1);
    add(I_NONE, O_RED, 9);
    add(I_NONE, O_GRN, 4);
    add(I_HOLD, O_GRN, 5);
    add(I_NONE, O_GRN, 4);
    add(I_NONE, O_YEL, 3);
    add(I_NONE, O_RED, 1);
    // Pedestrian request in RED: GREEN cut to 3 cycles, pending cleared on RED.
    add(I_RST,  O_RED, 1);
    add(I_PED,  O_RED | O_P, 1);
    add(I_NONE, O_RED | O_P, 8);
    add(I_NONE, O_GRN | O_P, 3);
    add(I_NONE, O_YEL | O_P, 3);
    add(I_NONE, O_RED, 1);
    // Request on the RED-entry edge is dropped; request under hold is ignored.
    add(I_RST,  O_RED, 1);
    add(I_NONE, O_RED, 9);
    add(I_NONE, O_GRN, 8);
    add(I_NONE, O_YEL, 3);
    add(I_PED,  O_RED, 1);
    add(I_HOLD | I_PED, O_RED, 1);
    add(I_NONE, O_RED, 1);
    add(I_PED,  O_RED | O_P, 1);
    // Reset in YELLOW cycle 2, then full RED; then reset+hold+ped in GREEN.
    add(I_RST,  O_RED, 1);
    add(I_NONE, O_RED, 9);
    add(I_NONE, O_GRN, 8);
    add(I_NONE, O_YEL, 2);
    add(I_RST,  O_RED, 1);
    add(I_NONE, O_RED, 9);
    add(I_NONE, O_GRN, 2);
    add(I_RST | I_HOLD | I_PED, O_RED, 1);
    add(I_NONE, O_RED, 9);
    add(I_NONE, O_GRN, 1);

    @(negedge clk);

    // Free run: 21-cycle period, position 0 is the reset edge.
    step(I_RST);
    check("reset_state", uo_out, O_RED);
    for (int k = 1; k <= 200; k++) begin
      step(I_NONE);
      p = k % 21;
      if (p < 10)      exp = O_RED;
      else if (p < 18) exp = O_GRN;
      else             exp = O_YEL;
      check($sformatf("free_run_k%0d", k), uo_out, exp);
      lamp = uo_out[2:0];
      check($sformatf("one_hot_k%0d", k), {7'd0, (lamp == 3'b100 || lamp == 3'b010 || lamp == 3'b001)}, 8'd1);
      check($sformatf("upper_zero_k%0d", k), {6'd0, uo_out[7:6]}, 8'd0);
      case (lamp)
        3'b001:  exp_state = 2'b01;
        3'b010:  exp_state = 2'b10;
        default: exp_state = 2'b00;
      endcase
      check($sformatf("state_code_k%0d", k), {6'd0, uo_out[4:3]}, {6'd0, exp_state});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ui);
      check($sformatf("vec%0d_ui%h", i, vecs[i].ui), uo_out, vecs[i].exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
